// File: rtl/mcse_ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the boot-control AHB master.
package mcse_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_PIPE,
      ST_LAST,
      ST_ERR
   } state_t;

   function automatic logic [2:0] hsize_enc(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/ahb_master_if_if.sv
// AHB-Lite signal bundle between the boot-control master and its slave.
interface ahb_bus_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   logic [AW-1:0] HADDR;
   logic          HWRITE;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic [2:0]    HBURST;
   logic [DW-1:0] HWDATA;
   logic [DW-1:0] HRDATA;
   logic          HREADY;
   logic          HRESP;

   modport master (
      output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
      output HRDATA, HREADY, HRESP
   );

endinterface

// File: rtl/ahb_payload_slicer.sv
// Picks the write beat out of the payload and merges a read beat into it.
module ahb_payload_slicer
   import mcse_ahb_pkg::*;
#(
   parameter int DW = 32,
   parameter int PW = 128,
   parameter int IW = 3
) (
   input  logic [IW-1:0] beat_idx,
   input  logic [PW-1:0] wdata,
   input  logic [PW-1:0] rdata,
   input  logic [DW-1:0] hrdata,
   output logic [DW-1:0] wbeat,
   output logic [PW-1:0] rdata_ins
);

   localparam int NB = PW / DW;

   always_comb begin
      wbeat     = '0;
      rdata_ins = rdata;
      for (int k = 0; k < NB; k++) begin
         if (beat_idx == IW'(k)) begin
            wbeat                  = wdata[k*DW +: DW];
            rdata_ins[k*DW +: DW]  = hrdata;
         end
      end
   end

endmodule

// File: rtl/ahb_master_if.sv
// Runs one payload read/write as pipelined AHB-Lite SINGLE beats per I_go.
// Optional HREADY-low timeout enabled by defining MCSE_AHB_TIMEOUT_EN.
`ifndef AHB_DATA_WIDTH_BITS
`define AHB_DATA_WIDTH_BITS 32
`endif
`ifndef IPID_WIDTH
`define IPID_WIDTH 128
`endif

module ahb_master_if
   import mcse_ahb_pkg::*;
#(
   parameter int pAHB_ADDR_WIDTH    = 32,
   parameter int pAHB_DATA_WIDTH    = `AHB_DATA_WIDTH_BITS,
   parameter int pPAYLOAD_SIZE_BITS = `IPID_WIDTH,
   parameter int pTIMEOUT_CYCLES    = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          I_go,
   input  logic [pAHB_ADDR_WIDTH-1:0]    I_int_addr,
   input  logic [pPAYLOAD_SIZE_BITS-1:0] I_int_wdata,
   input  logic                          I_int_write,
   output logic                          O_done,
   output logic [pPAYLOAD_SIZE_BITS-1:0] O_int_rdata,
   output logic                          O_int_rdata_valid,
   output logic                          O_err,
   ahb_bus_if.master                     bus
);

   localparam int AW  = pAHB_ADDR_WIDTH;
   localparam int D   = pAHB_DATA_WIDTH;
   localparam int P   = pPAYLOAD_SIZE_BITS;
   localparam int NB  = P / D;
   localparam int CW  = $clog2(NB + 1);
   localparam int BSH = $clog2(D / 8);
   localparam logic [AW-1:0] AMASK = ~AW'(D / 8 - 1);

   if ((D != 32 && D != 64) || (P % D) != 0 || NB < 1 || pTIMEOUT_CYCLES < 1) begin : g_param_err
      $error("ahb_master_if: unsupported parameter combination");
   end

   state_t          state_q, state_d;
   logic [AW-1:0]   base_q;
   logic            write_q;
   logic [P-1:0]    wdata_q, rdata_q, rdata_ins;
   logic [CW-1:0]   a_cnt_q, d_cnt_q;
   logic            done_q, valid_q, err_q;
   logic [D-1:0]    wbeat;
   logic [1:0]      htrans;
   logic            accept, a_adv, capture, fin_ok, fin_err;

`ifdef MCSE_AHB_TIMEOUT_EN
   localparam int TW = $clog2(pTIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt_q;
   logic          in_dphase, timeout;

   assign in_dphase = (state_q == ST_PIPE) || (state_q == ST_LAST) || (state_q == ST_ERR);
   assign timeout   = in_dphase && !bus.HREADY && (to_cnt_q == TW'(pTIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 to_cnt_q <= '0;
      else if (!in_dphase || bus.HREADY || timeout) to_cnt_q <= '0;
      else                                        to_cnt_q <= to_cnt_q + 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      htrans  = HTRANS_IDLE;
      accept  = 1'b0;
      a_adv   = 1'b0;
      capture = 1'b0;
      fin_ok  = 1'b0;
      fin_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_go) begin
               accept  = 1'b1;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            htrans = HTRANS_NONSEQ;
            if (bus.HREADY) begin
               a_adv   = 1'b1;
               state_d = (NB == 1) ? ST_LAST : ST_PIPE;
            end
         end
         ST_PIPE: begin
            // An error in the overlapping data phase cancels the pending address at once
            if (bus.HRESP) begin
               state_d = ST_ERR;
            end else begin
               htrans = HTRANS_NONSEQ;
               if (bus.HREADY) begin
                  capture = 1'b1;
                  a_adv   = 1'b1;
                  if (a_cnt_q == CW'(NB - 1)) state_d = ST_LAST;
               end
            end
         end
         ST_LAST: begin
            if (bus.HRESP) begin
               state_d = ST_ERR;
            end else if (bus.HREADY) begin
               capture = 1'b1;
               fin_ok  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            if (bus.HREADY) begin
               fin_err = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef MCSE_AHB_TIMEOUT_EN
      if (timeout) begin
         htrans  = HTRANS_IDLE;
         capture = 1'b0;
         a_adv   = 1'b0;
         fin_ok  = 1'b0;
         fin_err = 1'b1;
         state_d = ST_IDLE;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         a_cnt_q <= '0;
         d_cnt_q <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= fin_ok | fin_err;
         if (accept) begin
            base_q  <= I_int_addr & AMASK;
            write_q <= I_int_write;
            wdata_q <= I_int_wdata;
            a_cnt_q <= '0;
            d_cnt_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
         end
         // The beat whose address was just accepted becomes the next data-phase beat
         if (a_adv) begin
            a_cnt_q <= a_cnt_q + 1'b1;
            d_cnt_q <= a_cnt_q;
         end
         if (capture && !write_q) rdata_q <= rdata_ins;
         if (fin_ok)              valid_q <= !write_q;
         if (fin_err)             err_q   <= 1'b1;
      end
   end

   ahb_payload_slicer #(
      .DW (D),
      .PW (P),
      .IW (CW)
   ) u_slicer (
      .beat_idx  (d_cnt_q),
      .wdata     (wdata_q),
      .rdata     (rdata_q),
      .hrdata    (bus.HRDATA),
      .wbeat     (wbeat),
      .rdata_ins (rdata_ins)
   );

   assign bus.HTRANS = htrans;
   assign bus.HSIZE  = hsize_enc(D);
   assign bus.HBURST = HBURST_SINGLE;
   assign bus.HADDR  = (state_q == ST_ADDR || state_q == ST_PIPE) ?
                       base_q + (AW'(a_cnt_q) << BSH) : '0;
   assign bus.HWRITE = (state_q == ST_ADDR || state_q == ST_PIPE) && write_q;
   assign bus.HWDATA = ((state_q == ST_PIPE || state_q == ST_LAST) && write_q) ? wbeat : '0;

   assign O_done            = done_q;
   assign O_int_rdata       = rdata_q;
   assign O_int_rdata_valid = valid_q;
   assign O_err             = err_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Scoreboard bench for ahb_master_if with a directed AHB-Lite slave model (D=32, P=128).
`timescale 1ns/1ps
module tb_ahb_master_if;
   import mcse_ahb_pkg::*;

   localparam int AW = 32;
   localparam int D  = 32;
   localparam int P  = 128;
   localparam int N  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          I_go = 1'b0;
   logic [AW-1:0] I_int_addr = '0;
   logic [P-1:0]  I_int_wdata = '0;
   logic          I_int_write = 1'b0;
   logic          O_done;
   logic [P-1:0]  O_int_rdata;
   logic          O_int_rdata_valid;
   logic          O_err;

   ahb_bus_if #(.AW(AW), .DW(D)) bus ();

   ahb_master_if #(
      .pAHB_ADDR_WIDTH    (AW),
      .pAHB_DATA_WIDTH    (D),
      .pPAYLOAD_SIZE_BITS (P),
      .pTIMEOUT_CYCLES    (16)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .I_go              (I_go),
      .I_int_addr        (I_int_addr),
      .I_int_wdata       (I_int_wdata),
      .I_int_write       (I_int_write),
      .O_done            (O_done),
      .O_int_rdata       (O_int_rdata),
      .O_int_rdata_valid (O_int_rdata_valid),
      .O_err             (O_err),
      .bus               (bus)
   );

   typedef struct {
      logic         err;
      logic         vld;
      logic         chk_rd;
      logic [P-1:0] rdata;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   go_cyc = 0;
   int   done_cnt = 0;

   // slave configuration (written by the stimulus process only)
   logic [AW-1:0] cfg_base = '0;
   int            wait_beat = -1;
   int            wait_n = 0;
   int            err_beat = -1;
   logic          stuck = 1'b0;
   logic [D-1:0]  rd_tbl [N];

   // slave observations (written by the slave process only)
   logic [AW-1:0] log_addr[$];
   logic          log_wr[$];
   logic [D-1:0]  log_wdata[$];
   logic [1:0]    first_err_htrans;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // AHB-Lite slave: drives the response for the current data phase, then samples the address phase
   logic [AW-1:0] dp_addr = '0;
   logic          dp_v = 1'b0;
   logic          dp_wr = 1'b0;
   logic          err_2nd = 1'b0;
   int            wait_left = 0;
   int            dp_beat = 0;
   initial begin
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = '0;
      first_err_htrans = 2'b11;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dp_v = 1'b0; err_2nd = 1'b0; wait_left = 0;
            bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
         end else begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
            dp_beat = int'((dp_addr - cfg_base) >> 2);
            if (err_2nd) begin
               bus.HRESP = 1'b1; err_2nd = 1'b0; dp_v = 1'b0;
            end else if (dp_v) begin
               if (stuck) bus.HREADY = 1'b0;
               else if (wait_left > 0) begin
                  bus.HREADY = 1'b0; wait_left--;
               end else if (dp_beat == err_beat) begin
                  bus.HRESP = 1'b1; bus.HREADY = 1'b0; err_2nd = 1'b1;
               end else begin
                  if (dp_wr) log_wdata.push_back(bus.HWDATA);
                  else if (dp_beat >= 0 && dp_beat < N) bus.HRDATA = rd_tbl[dp_beat];
                  dp_v = 1'b0;
               end
            end
            #1;
            if (bus.HRESP && !bus.HREADY) first_err_htrans = bus.HTRANS;
            if (bus.HREADY && bus.HTRANS == HTRANS_NONSEQ) begin
               dp_addr = bus.HADDR; dp_wr = bus.HWRITE; dp_v = 1'b1;
               log_addr.push_back(bus.HADDR);
               log_wr.push_back(bus.HWRITE);
               wait_left = (int'((bus.HADDR - cfg_base) >> 2) == wait_beat) ? wait_n : 0;
            end
         end
      end
   end

   // completion monitor: every O_done pulse must match the oldest expected completion
   initial begin
      forever begin
         @(negedge clk);
         if (O_done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: O_done=1 at cycle %0d, expected no completion", cyc);
            end else begin
               e = sb_q.pop_front();
               check("done_latency", 128'(cyc - go_cyc + 1), 128'(e.lat));
               check("done_O_err", 128'(O_err), 128'(e.err));
               check("done_rdata_valid", 128'(O_int_rdata_valid), 128'(e.vld));
               if (e.chk_rd) check("done_rdata", O_int_rdata, e.rdata);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start(input logic wr, input logic [AW-1:0] a, input logic [P-1:0] wd);
      @(negedge clk);
      cfg_base    = a;
      I_go        = 1'b1;
      I_int_write = wr;
      I_int_addr  = a;
      I_int_wdata = wd;
      @(posedge clk);
      #1;
      I_go   = 1'b0;
      go_cyc = cyc;
   endtask

   task automatic wait_done(input int target, input int max_cyc, input string name);
      int i = 0;
      while (done_cnt < target && i < max_cyc) begin
         @(negedge clk);
         #1;
         i++;
      end
      check(name, 128'(done_cnt >= target), 128'(1));
   endtask

   logic [D-1:0] wexp [N];
   int a0, w0, d0;

   initial begin
      wexp = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
      rd_tbl = '{32'h1, 32'h2, 32'h3, 32'h4};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_HTRANS", 128'(bus.HTRANS), 128'(2'b00));
      check("rst_HADDR", 128'(bus.HADDR), 128'(0));
      check("rst_HWRITE", 128'(bus.HWRITE), 128'(0));
      check("rst_HWDATA", 128'(bus.HWDATA), 128'(0));
      check("rst_HSIZE", 128'(bus.HSIZE), 128'(3'd2));
      check("rst_HBURST", 128'(bus.HBURST), 128'(3'd0));
      check("rst_O_done", 128'(O_done), 128'(0));
      check("rst_O_err", 128'(O_err), 128'(0));
      check("rst_valid", 128'(O_int_rdata_valid), 128'(0));
      check("rst_rdata", O_int_rdata, 128'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // zero-wait write
      a0 = log_addr.size(); w0 = log_wdata.size(); d0 = done_cnt;
      sb_q.push_back('{err: 1'b0, vld: 1'b0, chk_rd: 1'b0, rdata: '0, lat: 6});
      start(1'b1, 32'h4000_0010, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      wait_done(d0 + 1, 20, "wr_done_seen");
      check("wr_beats", 128'(log_addr.size() - a0), 128'(4));
      check("wr_wbeats", 128'(log_wdata.size() - w0), 128'(4));
      for (int k = 0; k < N; k++) begin
         check($sformatf("wr_haddr%0d", k), 128'(log_addr[a0+k]), 128'(32'h4000_0010 + 4*k));
         check($sformatf("wr_hwrite%0d", k), 128'(log_wr[a0+k]), 128'(1));
         check($sformatf("wr_hwdata%0d", k), 128'(log_wdata[w0+k]), 128'(wexp[k]));
      end

      // read with two wait states on beat 2
      a0 = log_addr.size(); d0 = done_cnt;
      wait_beat = 2; wait_n = 2;
      sb_q.push_back('{err: 1'b0, vld: 1'b1, chk_rd: 1'b1,
                       rdata: 128'h00000004_00000003_00000002_00000001, lat: 8});
      start(1'b0, 32'h2000_0000, '0);
      wait_done(d0 + 1, 30, "rd_done_seen");
      wait_beat = -1;
      check("rd_beats", 128'(log_addr.size() - a0), 128'(4));
      check("rd_haddr3", 128'(log_addr[a0+3]), 128'(32'h2000_000C));
      repeat (200) @(negedge clk);
      check("rd_rdata_held", O_int_rdata, 128'h00000004_00000003_00000002_00000001);
      check("rd_valid_held", 128'(O_int_rdata_valid), 128'(1));

      // ERROR response on beat 1 of a write
      a0 = log_addr.size(); d0 = done_cnt;
      err_beat = 1;
      sb_q.push_back('{err: 1'b1, vld: 1'b0, chk_rd: 1'b0, rdata: '0, lat: 5});
      start(1'b1, 32'h3000_0000, 128'h44444444_33333333_22222222_11111111);
      wait_done(d0 + 1, 30, "err_done_seen");
      err_beat = -1;
      repeat (10) @(negedge clk);
      check("err_htrans_first", 128'(first_err_htrans), 128'(HTRANS_IDLE));
      check("err_beats", 128'(log_addr.size() - a0), 128'(2));
      check("err_done_count", 128'(done_cnt - d0), 128'(1));
      check("err_sticky", 128'(O_err), 128'(1));
      check("err_valid_low", 128'(O_int_rdata_valid), 128'(0));

      // I_go during a busy read and in its completion cycle
      rd_tbl = '{32'h11, 32'h22, 32'h33, 32'h44};
      a0 = log_addr.size(); d0 = done_cnt;
      sb_q.push_back('{err: 1'b0, vld: 1'b1, chk_rd: 1'b1,
                       rdata: 128'h00000044_00000033_00000022_00000011, lat: 6});
      start(1'b0, 32'h2000_0100, '0);
      repeat (3) @(negedge clk);
      I_go = 1'b1; I_int_write = 1'b1; I_int_addr = 32'h0BAD_0000;
      @(posedge clk); #1; I_go = 1'b0;
      repeat (2) @(negedge clk);
      I_go = 1'b1;
      @(posedge clk); #1; I_go = 1'b0;
      repeat (20) @(negedge clk);
      check("busy_done_count", 128'(done_cnt - d0), 128'(1));
      check("busy_beats", 128'(log_addr.size() - a0), 128'(4));
      check("busy_haddr0", 128'(log_addr[a0]), 128'(32'h2000_0100));

      // reset in the middle of the beat-2 data phase
      d0 = done_cnt;
      wait_beat = 2; wait_n = 3;
      start(1'b1, 32'h5000_0000, 128'h44444444_33333333_22222222_11111111);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_HTRANS", 128'(bus.HTRANS), 128'(HTRANS_IDLE));
      check("midrst_HADDR", 128'(bus.HADDR), 128'(0));
      check("midrst_HWRITE", 128'(bus.HWRITE), 128'(0));
      check("midrst_HWDATA", 128'(bus.HWDATA), 128'(0));
      check("midrst_O_done", 128'(O_done), 128'(0));
      check("midrst_O_err", 128'(O_err), 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_beat = -1;
      repeat (5) @(negedge clk);
      check("midrst_no_done", 128'(done_cnt - d0), 128'(0));

      a0 = log_addr.size(); w0 = log_wdata.size(); d0 = done_cnt;
      sb_q.push_back('{err: 1'b0, vld: 1'b0, chk_rd: 1'b0, rdata: '0, lat: 6});
      start(1'b1, 32'h6000_0000, 128'h44444444_33333333_22222222_11111111);
      wait_done(d0 + 1, 20, "postrst_done_seen");
      check("postrst_beats", 128'(log_addr.size() - a0), 128'(4));
      check("postrst_haddr0", 128'(log_addr[a0]), 128'(32'h6000_0000));
      check("postrst_hwdata3", 128'(log_wdata[w0+3]), 128'(32'h44444444));

      // HREADY stuck low in the data phase
      d0 = done_cnt;
      stuck = 1'b1;
`ifdef MCSE_AHB_TIMEOUT_EN
      sb_q.push_back('{err: 1'b1, vld: 1'b0, chk_rd: 1'b0, rdata: '0, lat: 18});
      start(1'b0, 32'h7000_0000, '0);
      wait_done(d0 + 1, 60, "timeout_done_seen");
      check("timeout_err", 128'(O_err), 128'(1));
`else
      start(1'b0, 32'h7000_0000, '0);
      repeat (1000) @(negedge clk);
      check("stuck_no_done", 128'(done_cnt - d0), 128'(0));
`endif
      stuck = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("final_HTRANS", 128'(bus.HTRANS), 128'(HTRANS_IDLE));
      check("sb_drained", 128'(sb_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
